// File: rtl/image_scanner.sv
// Streams a snapshot of the flat image word out one pixel per handshake in raster order.
// Optional build macro IMAGE_SCANNER_CONTINUOUS_EN: rescan the frame continuously after one start.
module image_scanner #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = 3,
  parameter int CW   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] image,
  input  logic                 pix_ready,
  output logic                 pix_valid,
  output logic                 pix,
  output logic [RW-1:0]        pix_row,
  output logic [CW-1:0]        pix_col,
  output logic                 pix_last,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int NPIX = ROWS * COLS;
  localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state_q, state_d;
  logic [NPIX-1:0] snap_q, snap_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [IW-1:0]   pix_idx;
  logic            at_last;
  logic            scan;

  // Pixel mux reads straight from the registered row/col; no extra stage.
  assign pix_idx = IW'(row_q) * IW'(COLS) + IW'(col_q);
  assign at_last = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));
  assign scan    = (state_q == SCAN);

  always_comb begin
    pix_valid  = scan;
    pix        = scan & snap_q[pix_idx];
    pix_row    = scan ? row_q : '0;
    pix_col    = scan ? col_q : '0;
    pix_last   = scan & at_last;
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = image;
          row_d   = '0;
          col_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (pix_ready) begin
          // Counters park on the last pixel rather than wrapping.
          if (at_last) begin
            state_d = DONE;
          end else if (col_q == CW'(COLS - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DONE: begin
`ifdef IMAGE_SCANNER_CONTINUOUS_EN
        snap_d  = image;
        row_d   = '0;
        col_d   = '0;
        state_d = SCAN;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

endmodule

// File: tb/tb_image_scanner.sv
// Directed bench for image_scanner (8x8); continuous-mode steps run when IMAGE_SCANNER_CONTINUOUS_EN is defined.
module tb_image_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] image;
  logic        pix_ready;
  logic        pix_valid;
  logic        pix;
  logic [2:0]  pix_row;
  logic [2:0]  pix_col;
  logic        pix_last;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  image_scanner #(.ROWS(8), .COLS(8), .RW(3), .CW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .image(image), .pix_ready(pix_ready),
    .pix_valid(pix_valid), .pix(pix), .pix_row(pix_row), .pix_col(pix_col),
    .pix_last(pix_last), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] exp_vec(input int i, input logic [63:0] img);
    logic [2:0] r, c;
    r = 3'(i / 8);
    c = 3'(i % 8);
    return {1'b1, img[i], r, c, (i == 63)};
  endfunction

  function automatic logic [8:0] obs_vec();
    return {pix_valid, pix, pix_row, pix_col, pix_last};
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [63:0] img_a, img_b;
    int k, cyc, fd_cnt, ones, any_valid, t_fd1, t_fd2;

    rst = 1'b1; start = 1'b0; image = '0; pix_ready = 1'b0;
    #3;
    chk("reset_outputs", {pix_valid, pix, pix_row, pix_col, pix_last, busy, frame_done}, 0);
    tick(); tick();
    rst = 1'b0;

    // Idle with start low: nothing comes out.
    any_valid = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      any_valid = any_valid | int'(pix_valid) | int'(busy);
    end
    chk("idle_no_valid", any_valid, 0);

    // Full frame with ready held high.
    img_a = 64'h8000_0000_0000_0001;
    image = img_a;
    pix_ready = 1'b1;
    do_start();
    chk("first_pixel_latency", {pix_valid, busy, pix}, 3'b111);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("full_pix_%0d", i), obs_vec(), exp_vec(i, img_a));
      tick();
    end
    chk("full_frame_done", {frame_done, busy, pix_valid}, 3'b110);
    tick();
    chk("full_after_done", {frame_done, busy, pix_valid}, 3'b000);
    tick(); tick();
    chk("full_no_restart", {pix_valid, busy}, 2'b00);

    // Backpressure: ready pattern 1,0,0 repeating.
    img_a = 64'hA5C3_0F1E_7788_9AB1;
    image = img_a;
    pix_ready = 1'b0;
    do_start();
    k = 0; cyc = 0; fd_cnt = 0;
    while (k < 64 && cyc < 400) begin
      if (obs_vec() !== exp_vec(k, img_a))
        chk($sformatf("bp_pix_%0d_cyc_%0d", k, cyc), obs_vec(), exp_vec(k, img_a));
      fd_cnt += int'(frame_done);
      pix_ready = (cyc % 3 == 0);
      @(posedge clk);
      if (pix_ready) k++;
      #1;
      cyc++;
    end
    chk("bp_transfers", k, 64);
    chk("bp_cycles", cyc, 190);
    pix_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fd_cnt += int'(frame_done);
      tick();
    end
    chk("bp_frame_done_once", fd_cnt, 1);

    // Snapshot isolation: image drops to zero right after start.
    image = '1;
    do_start();
    image = '0;
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      ones += int'(pix_valid & pix);
      tick();
    end
    chk("snapshot_ones", ones, 64);
    tick(); tick();

    // Ignored start mid-frame, then asynchronous abort.
    img_a = 64'h0123_4567_89AB_CDEF;
    image = img_a;
    do_start();
    for (int i = 0; i < 30; i++) begin
      if (obs_vec() !== exp_vec(i, img_a))
        chk($sformatf("restart_pix_%0d", i), obs_vec(), exp_vec(i, img_a));
      start = (i == 10);
      tick();
    end
    start = 1'b0;
    chk("ignored_start_pix30", obs_vec(), exp_vec(30, img_a));
    #3;
    rst = 1'b1;
    #1;
    chk("abort_async", {pix_valid, pix, pix_row, pix_col, pix_last, busy, frame_done}, 0);
    tick();
    rst = 1'b0;
    fd_cnt = 0; any_valid = 0;
    for (int i = 0; i < 5; i++) begin
      fd_cnt += int'(frame_done);
      any_valid |= int'(pix_valid);
      tick();
    end
    chk("abort_no_frame_done", {fd_cnt, any_valid}, 0);
    img_b = 64'hFFFF_0000_FFFF_0003;
    image = img_b;
    do_start();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fresh_pix_%0d", i), obs_vec(), exp_vec(i, img_b));
      tick();
    end

`ifdef IMAGE_SCANNER_CONTINUOUS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    img_a = 64'h0000_0000_0000_00FF;
    img_b = 64'hF0F0_F0F0_0F0F_0F0F;
    image = img_a;
    do_start();
    cyc = 0;
    for (int i = 0; i < 64; i++) begin
      if (obs_vec() !== exp_vec(i, img_a))
        chk($sformatf("cont_f1_pix_%0d", i), obs_vec(), exp_vec(i, img_a));
      tick(); cyc++;
    end
    t_fd1 = cyc;
    chk("cont_bubble", {frame_done, pix_valid, busy}, 3'b101);
    image = img_b;
    tick(); cyc++;
    for (int i = 0; i < 64; i++) begin
      if (obs_vec() !== exp_vec(i, img_b))
        chk($sformatf("cont_f2_pix_%0d", i), obs_vec(), exp_vec(i, img_b));
      tick(); cyc++;
    end
    t_fd2 = cyc;
    chk("cont_frame_done2", {frame_done, pix_valid}, 2'b10);
    chk("cont_fd_spacing", t_fd2 - t_fd1, 65);
    tick();
    chk("cont_rescan", {pix_valid, busy, pix_row, pix_col}, 8'b1100_0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
